// File: rtl/disc_reader_if.sv
// Acquisition-memory write port of disc_reader: byte, strobe and back-pressure.
interface disc_reader_if;
  logic [7:0] mdat;
  logic       mwrite;
  logic       mem_full;

  modport master (output mdat, output mwrite, input mem_full);
  modport slave  (input mdat, input mwrite, output mem_full);
endinterface

// File: rtl/disc_reader.sv
// Flux-transition acquisition: timestamps read-data falling edges in clken ticks.
// Define DISC_READER_INDEX_STORE_EN to also write 0x80 index markers.
module disc_reader (
  input  logic          clock,
  input  logic          reset,
  input  logic          clken,
  input  logic          rddata,
  input  logic          index,
  input  logic          trkmark,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    start_mode,
  input  logic [5:0]    stop_idx,
  disc_reader_if.master mem,
  output logic          running,
  output logic          acquiring
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACQ} state_t;

  state_t      state, state_n;
  logic [1:0]  rd_sr, ix_sr;
  logic [6:0]  cnt, cnt_n;
  logic [5:0]  stop_cnt, stop_n;
  logic [7:0]  mdat_q, mdat_n;
  logic        mwrite_q, mwrite_n;
  logic        rd_edge, ix_edge, arm_go;
`ifdef DISC_READER_INDEX_STORE_EN
  logic        pend, pend_n;
`endif

  assign rd_edge    = (rd_sr == 2'b10);
  assign ix_edge    = (ix_sr == 2'b01);
  assign running    = (state != S_IDLE);
  assign acquiring  = (state == S_ACQ);
  assign mem.mdat   = mdat_q;
  assign mem.mwrite = mwrite_q;

  always_comb begin
    case (start_mode)
      2'b01:   arm_go = ix_edge;
      2'b10:   arm_go = trkmark;
      default: arm_go = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stop_n   = stop_cnt;
    mdat_n   = '0;
    mwrite_n = 1'b0;
`ifdef DISC_READER_INDEX_STORE_EN
    pend_n   = pend;
`endif
    case (state)
      S_IDLE: if (start) state_n = S_ARM;
      S_ARM: begin
        if (arm_go) begin
          state_n = S_ACQ;
          cnt_n   = 7'd1;
          stop_n  = stop_idx;
`ifdef DISC_READER_INDEX_STORE_EN
          pend_n  = 1'b0;
`endif
        end
      end
      S_ACQ: begin
        if (mem.mem_full) begin
          state_n = S_IDLE;
        end else if (ix_edge && stop_cnt == 6'd1) begin
`ifdef DISC_READER_INDEX_STORE_EN
          mwrite_n = 1'b1;
          mdat_n   = 8'h80;
`endif
          state_n = S_IDLE;
        end else begin
          if (ix_edge && stop_cnt > 6'd1) stop_n = stop_cnt - 6'd1;
          // Read edge and carry reload the interval; a marker write still counts time.
          if (rd_edge) begin
            mwrite_n = 1'b1;
            mdat_n   = {1'b0, cnt};
            cnt_n    = 7'd1;
          end else if (cnt == 7'd127) begin
            mwrite_n = 1'b1;
            mdat_n   = 8'h00;
            cnt_n    = 7'd1;
          end else begin
            cnt_n = cnt + 7'd1;
`ifdef DISC_READER_INDEX_STORE_EN
            if (pend) begin
              mwrite_n = 1'b1;
              mdat_n   = 8'h80;
              pend_n   = 1'b0;
            end
`endif
          end
`ifdef DISC_READER_INDEX_STORE_EN
          if (ix_edge && !pend) pend_n = 1'b1;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n  = S_IDLE;
      mwrite_n = 1'b0;
      mdat_n   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_sr    <= '0;
      ix_sr    <= '0;
      cnt      <= '0;
      stop_cnt <= '0;
      mdat_q   <= '0;
      mwrite_q <= 1'b0;
`ifdef DISC_READER_INDEX_STORE_EN
      pend     <= 1'b0;
`endif
    end else if (clken) begin
      state    <= state_n;
      rd_sr    <= {rd_sr[0], rddata};
      ix_sr    <= {ix_sr[0], index};
      cnt      <= cnt_n;
      stop_cnt <= stop_n;
      mdat_q   <= mdat_n;
      mwrite_q <= mwrite_n;
`ifdef DISC_READER_INDEX_STORE_EN
      pend     <= pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_disc_reader.sv
// Bench for disc_reader: timestamp-based model checked every clock plus literal byte expectations.
module tb_disc_reader;

`ifdef DISC_READER_INDEX_STORE_EN
  localparam bit MARK = 1'b1;
`else
  localparam bit MARK = 1'b0;
`endif

  logic       clock = 1'b0, reset = 1'b1, clken = 1'b0;
  logic       rddata = 1'b1, index = 1'b0, trkmark = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [1:0] start_mode = 2'b00;
  logic [5:0] stop_idx = 6'd0;
  logic       running, acquiring;

  disc_reader_if mem_bus ();

  disc_reader dut (
    .clock      (clock),
    .reset      (reset),
    .clken      (clken),
    .rddata     (rddata),
    .index      (index),
    .trkmark    (trkmark),
    .start      (start),
    .abort      (abort),
    .start_mode (start_mode),
    .stop_idx   (stop_idx),
    .mem        (mem_bus.master),
    .running    (running),
    .acquiring  (acquiring)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: phase 0 idle, 1 armed, 2 acquiring; intervals from tick timestamps.
  int         m_phase = 0, m_t = 0, m_ref = 0, m_left = 0;
  bit         m_pend = 1'b0;
  bit         rd_hist[$];
  bit         ix_hist[$];
  bit         exp_w = 1'b0;
  logic [7:0] exp_d = 8'h00;
  logic [7:0] wlog[$];

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_pend  = 1'b0;
    exp_w   = 1'b0;
    exp_d   = 8'h00;
    rd_hist.delete();
    ix_hist.delete();
    rd_hist.push_back(1'b0); rd_hist.push_back(1'b0);
    ix_hist.push_back(1'b0); ix_hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit rd_e, ix_e, go, was_pend;
    int el;
    rd_e  = rd_hist[rd_hist.size()-2] && !rd_hist[rd_hist.size()-1];
    ix_e  = !ix_hist[ix_hist.size()-2] && ix_hist[ix_hist.size()-1];
    exp_w = 1'b0;
    exp_d = 8'h00;
    if (abort) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) m_phase = 1;
    end else if (m_phase == 1) begin
      go = (start_mode == 2'b01) ? ix_e : (start_mode == 2'b10) ? trkmark : 1'b1;
      if (go) begin
        m_phase = 2;
        m_ref   = m_t;
        m_left  = int'(stop_idx);
        m_pend  = 1'b0;
      end
    end else begin
      if (mem_bus.mem_full) begin
        m_phase = 0;
      end else if (ix_e && m_left == 1) begin
        exp_w   = MARK;
        exp_d   = MARK ? 8'h80 : 8'h00;
        m_phase = 0;
      end else begin
        was_pend = m_pend;
        if (ix_e && m_left > 1) m_left--;
        el = m_t - m_ref;
        if (rd_e) begin
          exp_w = 1'b1; exp_d = 8'(el); m_ref = m_t;
        end else if (el == 127) begin
          exp_w = 1'b1; exp_d = 8'h00; m_ref = m_t;
        end else if (m_pend) begin
          exp_w = 1'b1; exp_d = 8'h80; m_pend = 1'b0;
        end
        if (ix_e && MARK && !was_pend) m_pend = 1'b1;
      end
    end
    rd_hist.push_back(rddata);
    ix_hist.push_back(index);
    m_t++;
  endtask

  always @(posedge clock) begin : cmp
    bit was_tick;
    was_tick = clken && !reset;
    if (reset) model_reset();
    else if (clken) model_step();
    #1;
    check("running", {31'b0, running}, {31'b0, m_phase != 0});
    check("acquiring", {31'b0, acquiring}, {31'b0, m_phase == 2});
    check("mwrite", {31'b0, mem_bus.mwrite}, {31'b0, exp_w});
    if (exp_w) check("mdat", {24'b0, mem_bus.mdat}, {24'b0, exp_d});
    if (was_tick && mem_bus.mwrite) wlog.push_back(mem_bus.mdat);
  end

  function automatic logic [31:0] lg(input int i);
    if (i < wlog.size()) return {24'b0, wlog[i]};
    return 32'h100;
  endfunction

  task automatic tick();
    @(negedge clock); clken = 1'b1;
    @(negedge clock); clken = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_pulse();
    rddata = 1'b0; tick(); rddata = 1'b1;
  endtask

  task automatic begin_acq(input logic [1:0] mode, input logic [5:0] stop);
    wlog.delete();
    start_mode = mode;
    stop_idx   = stop;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  initial begin
    mem_bus.mem_full = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_running", {31'b0, running}, 32'd0);
    check("rst_mwrite", {31'b0, mem_bus.mwrite}, 32'd0);
    check("rst_mdat", {24'b0, mem_bus.mdat}, 32'd0);
    reset = 1'b0;
    ticks(3);

    // 40-tick pulse train, immediate start
    begin_acq(2'b00, 6'd0); tick();
    check("A_acquiring", {31'b0, acquiring}, 32'd1);
    for (int p = 0; p < 5; p++) begin ticks(39); rd_pulse(); end
    ticks(3);
    check("A_count", wlog.size(), 32'd5);
    check("A_byte0", lg(0), 32'h29);
    for (int i = 1; i < 5; i++) check("A_byte", lg(i), 32'h28);
    do_abort();
    check("A_idle", {31'b0, running}, 32'd0);

    // 300-tick interval splits into carries
    begin_acq(2'b00, 6'd0); tick();
    rd_pulse(); ticks(299); rd_pulse(); ticks(3);
    check("B_count", wlog.size(), 32'd4);
    check("B_byte0", lg(0), 32'h02);
    check("B_byte1", lg(1), 32'h00);
    check("B_byte2", lg(2), 32'h00);
    check("B_byte3", lg(3), 32'h2E);
    do_abort();

    // index edge coincident with read edge at interval 20
    begin_acq(2'b00, 6'd0); tick();
    ticks(18);
    rddata = 1'b0; index = 1'b1; tick();
    rddata = 1'b1; index = 1'b0; tick();
    ticks(3);
    check("C_count", wlog.size(), MARK ? 32'd2 : 32'd1);
    check("C_byte0", lg(0), 32'h14);
    check("C_byte1", lg(1), MARK ? 32'h80 : 32'h100);
    do_abort();

    // start at index, stop after two further index edges
    begin_acq(2'b01, 6'd2);
    ticks(3);
    check("D_armed_run", {31'b0, running}, 32'd1);
    check("D_armed_acq", {31'b0, acquiring}, 32'd0);
    index = 1'b1; tick(); index = 1'b0; tick();
    check("D_acq", {31'b0, acquiring}, 32'd1);
    ticks(10);
    index = 1'b1; tick(); index = 1'b0; ticks(10);
    check("D_still_run", {31'b0, running}, 32'd1);
    index = 1'b1; tick(); index = 1'b0; tick();
    check("D_stopped", {31'b0, running}, 32'd0);
    check("D_count", wlog.size(), MARK ? 32'd2 : 32'd0);
    check("D_byte0", lg(0), MARK ? 32'h80 : 32'h100);

    // memory full mid-stream
    begin_acq(2'b00, 6'd0); tick();
    ticks(9); rd_pulse(); ticks(9);
    mem_bus.mem_full = 1'b1; rddata = 1'b0; tick();
    check("E_idle", {31'b0, running}, 32'd0);
    check("E_nowrite", {31'b0, mem_bus.mwrite}, 32'd0);
    mem_bus.mem_full = 1'b0; rddata = 1'b1; ticks(2);
    check("E_count", wlog.size(), 32'd1);
    check("E_byte0", lg(0), 32'h0B);

    // abort while armed
    begin_acq(2'b01, 6'd0); ticks(2);
    check("F_armed", {31'b0, running}, 32'd1);
    do_abort();
    check("F_running", {31'b0, running}, 32'd0);
    check("F_acquiring", {31'b0, acquiring}, 32'd0);
    check("F_mwrite", {31'b0, mem_bus.mwrite}, 32'd0);
    check("F_mdat", {24'b0, mem_bus.mdat}, 32'd0);

    // reset during acquisition with a write on the port
    begin_acq(2'b00, 6'd0); tick();
    ticks(4);
    rddata = 1'b0; tick(); rddata = 1'b1; tick();
    check("G_mwrite", {31'b0, mem_bus.mwrite}, 32'd1);
    check("G_mdat", {24'b0, mem_bus.mdat}, 32'h06);
    #2 reset = 1'b1;
    #1;
    check("G_rst_running", {31'b0, running}, 32'd0);
    check("G_rst_acq", {31'b0, acquiring}, 32'd0);
    check("G_rst_mwrite", {31'b0, mem_bus.mwrite}, 32'd0);
    check("G_rst_mdat", {24'b0, mem_bus.mdat}, 32'd0);
    @(negedge clock); reset = 1'b0;
    ticks(3);
    check("G_after", {31'b0, running}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/disc_reader.md
# disc_reader

Flux-transition acquisition engine: the read-side counterpart of the disc write sequencer. It timestamps falling edges on the drive's read-data line in units of `clken` ticks and streams one byte per event into acquisition memory through a write strobe. It can optionally mark index pulses in the stream. It sits between the drive interface pins and the acquisition memory controller, and is started and stopped by host control registers.

## Interface
Parameters:
- none. All behaviour is fixed, or selected by ports and the configuration macro.

Ports:
- `clock`  in  1  master clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clken`  in  1  clock enable. All sequential behaviour advances only on `clock` edges with `clken`=1 ("ticks").
- `rddata`  in  1  drive read data, active-low pulses.
- `index`  in  1  index pulse, active-high.
- `trkmark`  in  1  hard-sector track mark detect, active-high.
- `start`  in  1  begin acquisition (sampled in IDLE).
- `abort`  in  1  stop acquisition.
- `start_mode`  in  2  00 = immediate, 01 = at next index edge, 10 = when `trkmark` is high, 11 = same as 00.
- `stop_idx`  in  6  number of index edges after which acquisition stops; 0 = no index stop.
- `mem_full`  in  1  memory controller cannot accept more bytes.
- `mdat`  out  8  byte to write.
- `mwrite`  out  1  write strobe. The controller writes `mdat` and increments its address on a tick where `mwrite`=1.
- `running`  out  1  high when state ≠ IDLE.
- `acquiring`  out  1  high when state = ACQ.

## Operation
- Edge detectors:
  - `rddata` shifts into a 2-bit register each tick; a read edge is the register value {1,0}.
  - `index` shifts into a 2-bit register each tick; an index edge is {0,1}.
  - Both detectors run in every state.
- States:
  - IDLE: `start`=1 → ARM.
  - ARM: waits for the condition selected by `start_mode` → ACQ. In immediate mode, ARM lasts exactly one tick. The index edge that arms acquisition is neither recorded nor counted.
  - ACQ: event recording, described below.
  - `abort`=1 in any state → IDLE on that tick, with no write on that tick.
- Entry to ACQ:
  - interval counter (7 bits) ← 1;
  - stop counter (6 bits) ← `stop_idx`;
  - index pending flag ← 0.
- Byte encoding: 0x00 = carry (127 ticks elapsed, no transition); 0x01–0x7F = transition n ticks after the previous event; 0x80 = index marker.
- ACQ, per tick, in priority order:
  1. `mem_full`=1: no write; → IDLE.
  2. Final index edge (stop counter = 1 and an index edge): write 0x80 if markers are enabled; any simultaneous transition is discarded; → IDLE.
  3. Read edge: write {0, counter}; counter ← 1.
  4. Counter = 127 with no read edge: write 0x00; counter ← 1.
  5. Index pending: write 0x80; clear pending.
  6. Otherwise: no write; counter ← counter + 1.
- After cases 3, 4 and 5, the counter still increments when the tick is not itself a case 3/4 reload.
- Index edge while stop counter > 1: decrement the stop counter and set pending (markers enabled). An index edge while pending is already set is dropped; pending stays set.
- Index edge with stop counter = 0: never stops and never decrements.

## Timing
- Reset values: `mdat`=0x00, `mwrite`=0, `running`=0, `acquiring`=0, all counters and detectors 0, state IDLE.
- `mwrite` and `mdat` are registered and hold for one full tick period, which may span several clocks. The controller qualifies writes with `clken`.
- At most one write per tick, never while `mem_full`=1.
- Latency: `rddata` first sampled low at tick k → `mwrite`=1 after tick k+1.
- The interval byte equals the tick distance between consecutive detected read edges. Intervals over 127 ticks are written as 0x00 bytes followed by the remainder (interval − 127·m).
- Reset mid-acquisition: outputs return to reset values immediately, with no partial write.

## Configuration
- `DISC_READER_INDEX_STORE_EN` defined: index markers (0x80) are written as above, through the 1-deep pending flag.
- Undefined: no 0x80 bytes are ever produced and the pending logic is removed. Index edges still arm acquisition (mode 01) and drive `stop_idx`. On the final index edge the block goes to IDLE without writing.

## Test plan
- `start_mode`=00, `rddata` pulses 40 ticks apart → bytes 0x28 repeated; `acquiring` high throughout.
- Two pulses 300 ticks apart → 0x00, 0x00, 0x2E.
- Macro defined, index edge on the same tick as a read edge with counter 20 → 0x14, then 0x80 on the next tick.
- `start_mode`=01, `stop_idx`=2 → ACQ begins at the 1st index edge; second edge recorded; IDLE at the 3rd edge, `running`=0 one tick later.
- `mem_full` raised mid-stream → no further `mwrite`; IDLE next tick.
- `abort` in ARM, and `reset` during ACQ → IDLE; all outputs at reset values.
